// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state type,
// default memory map constants and the read encoding of the write strobes.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0000_2000;
    localparam int          DMEM_DEPTH_WORDS = 1024;
    localparam logic [3:0]  WR_EN_READ       = 4'b0000;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic [3:0]        wr_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // The read register only loads on an explicit read so it holds the
    // sampled word for as long as the response is pending.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES
// wait states, then presents a response held until the requester takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wr_en,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          ADDR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [2:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    dmem_state_t       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic              accept;
    logic              in_range;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        ram_wr_en;
    logic              ram_rd_en;
    logic [31:0]       ram_rdata;

    assign req_ready = (state_q == IDLE);
    assign accept    = rst_n && req_valid && req_ready;

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign in_range  = ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, req_addr} < END_ADDR);
    assign word_idx  = ADDR_W'((req_addr - BASE_ADDR) >> 2);
    assign ram_wr_en = (accept && in_range) ? req_wr_en : WR_EN_READ;
    assign ram_rd_en = accept && in_range && (req_wr_en == WR_EN_READ);

    byte_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .addr (word_idx),
        .rd_en(ram_rd_en),
        .wr_en(ram_wr_en),
        .wdata(req_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = !in_range;
                    wr_d  = (req_wr_en != WR_EN_READ);
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

    // Response fields are gated by state, so they read as zero whenever no response is pending.
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !wr_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a transaction-level memory model plus directed
// vectors for the data-memory responder (WAIT_CYCLES=1 and WAIT_CYCLES=0).
module tb_dmem_responder;

    localparam int          W     = 1;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wr_en;

    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_wr_en;

    int vectors     = 0;
    int miscompares = 0;

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr_en(req_wr_en), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
        .req_wr_en(z_req_wr_en), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Model state: one outstanding transaction, its age in edges since accept.
    logic [31:0] model_mem [int];
    bit          m_pending = 1'b0;
    int          m_age     = 0;
    logic [31:0] m_rdata   = 32'd0;
    bit          m_err     = 1'b0;
    bit          live      = 1'b0;

    task automatic modelAccept();
        longint      off;
        int          idx;
        logic [31:0] cur;
        off = longint'(req_addr) - longint'(BASE);
        if (off >= 0 && off < 4 * DEPTH) begin
            idx   = int'(off >> 2);
            cur   = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxx_xxxx;
            m_err = 1'b0;
            if (req_wr_en == 4'b0000) begin
                m_rdata = cur;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (req_wr_en[i]) cur[8*i +: 8] = req_wdata[8*i +: 8];
                model_mem[idx] = cur;
                m_rdata = 32'd0;
            end
        end else begin
            m_rdata = 32'd0;
            m_err   = 1'b1;
        end
        m_pending = 1'b1;
        m_age     = 1;
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pending = 1'b0;
                live      = 1'b1;
            end else if (!m_pending) begin
                if (req_valid) modelAccept();
            end else if (m_age >= W + 1 && rsp_ready) begin
                m_pending = 1'b0;
            end else begin
                m_age++;
            end
        end
    end

    initial begin : compare_proc
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (live) begin
                exp_valid = m_pending && (m_age >= W + 1);
                checkOutput("req_ready", {31'd0, req_ready}, {31'd0, !m_pending});
                checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
                if (exp_valid) begin
                    checkOutput("rsp_rdata", rsp_rdata, m_rdata);
                    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
                end
            end
        end
    end

    // Presents a request, waits for it to be accepted, then scrambles the idle inputs.
    task automatic issueRequest(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
        int n = 0;
        req_addr  = addr;
        req_wr_en = we;
        req_wdata = wd;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: req_ready=%b, required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = addr ^ 32'hFFFF_FFF0;
        req_wr_en = 4'hF;
        req_wdata = 32'hBAD0_BAD0;
    endtask

    task automatic finishResponse(input int hold, output logic [31:0] rd, output logic er, output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [3:0] we,
                                 input logic [31:0] wd, input int hold,
                                 input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        issueRequest(addr, we, wd);
        finishResponse(hold, rd, er, lat);
        checkOutput({name, "_rdata"}, rd, exp_rd);
        checkOutput({name, "_err"}, {31'd0, er}, {31'd0, exp_err});
        checkOutput({name, "_latency"}, lat, W + 1);
    endtask

    initial begin : stimulus
        rst_n       = 1'b0;
        rsp_ready   = 1'b0;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_2000;
        req_wr_en   = 4'hF;
        req_wdata   = 32'hFFFF_FFFF;
        z_req_valid = 1'b0;
        z_rsp_ready = 1'b0;
        z_req_addr  = 32'd0;
        z_req_wr_en = 4'h0;
        z_req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);

        applyStimulus("wr_full",   32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0);
        applyStimulus("rd_full",   32'h0000_2000, 4'b0000, 32'h0,         0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus("preload",   32'h0000_2004, 4'b1111, 32'h0000_0000, 0, 32'h0000_0000, 1'b0);
        applyStimulus("wr_byte1",  32'h0000_2004, 4'b0010, 32'h0000_AB00, 0, 32'h0000_0000, 1'b0);
        applyStimulus("wr_hi",     32'h0000_2004, 4'b1100, 32'h1234_0000, 0, 32'h0000_0000, 1'b0);
        applyStimulus("rd_lanes",  32'h0000_2004, 4'b0000, 32'h0,         0, 32'h1234_AB00, 1'b0);
        applyStimulus("wr_top",    32'h0000_2FFC, 4'b1111, 32'hA5A5_5A5A, 0, 32'h0000_0000, 1'b0);
        applyStimulus("wr_below",  32'h0000_1FFC, 4'b1111, 32'h1111_1111, 0, 32'h0000_0000, 1'b1);
        applyStimulus("wr_above",  32'h0000_3000, 4'b1111, 32'h2222_2222, 0, 32'h0000_0000, 1'b1);
        applyStimulus("rd_above",  32'h0000_3000, 4'b0000, 32'h0,         0, 32'h0000_0000, 1'b1);
        applyStimulus("rd_top",    32'h0000_2FFC, 4'b0000, 32'h0,         0, 32'hA5A5_5A5A, 1'b0);
        applyStimulus("rd_bp",     32'h0000_2000, 4'b0000, 32'h0,         5, 32'hDEAD_BEEF, 1'b0);
        applyStimulus("wr_sparse", 32'h0000_2006, 4'b1010, 32'hFF00_EE00, 0, 32'h0000_0000, 1'b0);
        applyStimulus("rd_sparse", 32'h0000_2007, 4'b0000, 32'h0,         0, 32'hFF34_EE00, 1'b0);

        issueRequest(32'h0000_2008, 4'b1111, 32'h55AA_55AA);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        applyStimulus("rd_after_rst", 32'h0000_2008, 4'b0000, 32'h0, 0, 32'h55AA_55AA, 1'b0);

        checkOutput("w0_ready", {31'd0, z_req_ready}, 32'd1);
        z_req_addr  = 32'h0000_2010;
        z_req_wr_en = 4'b1111;
        z_req_wdata = 32'hCAFE_F00D;
        z_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_req_valid = 1'b0;
        checkOutput("w0_wr_valid", {31'd0, z_rsp_valid}, 32'd1);
        checkOutput("w0_wr_err", {31'd0, z_rsp_err}, 32'd0);
        z_rsp_ready = 1'b1;
        @(negedge clk);
        z_rsp_ready = 1'b0;
        checkOutput("w0_idle", {31'd0, z_req_ready}, 32'd1);
        z_req_wr_en = 4'b0000;
        z_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_req_valid = 1'b0;
        checkOutput("w0_rd_valid", {31'd0, z_rsp_valid}, 32'd1);
        checkOutput("w0_rd_rdata", z_rsp_rdata, 32'hCAFE_F00D);
        z_rsp_ready = 1'b1;
        @(negedge clk);
        z_rsp_ready = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
